// File: rtl/vedic_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// State encoding and default geometry used by the top and its step cell.
package vedic_div_pkg;

    localparam int DIV_ST_W      = 2;
    localparam int DIV_DEF_WIDTH = 4;

    typedef enum logic [DIV_ST_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/vedic_div_step.sv
// One combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and tries a subtract.
// The partial remainder entering a step is always below 2^(WIDTH-1), so only its
// low WIDTH-1 bits are carried in.
import vedic_div_pkg::*;

module vedic_div_step #(
    parameter int WIDTH = DIV_DEF_WIDTH
) (
    input  logic [WIDTH-2:0] acc,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             qbit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    // trial subtract in WIDTH+1 bits; the top bit is the borrow
    always_comb begin
        shifted = {acc, dbit};
        trial   = {1'b0, shifted} - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            acc_nxt = trial[WIDTH-1:0];
            qbit    = 1'b1;
        end else begin
            acc_nxt = shifted;
            qbit    = 1'b0;
        end
    end

endmodule

// File: rtl/vedic_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// start/done handshake; q/r/div_by_zero held until the next result lands.
// Optional result self-check: define VEDIC_DIV_CHECK_EN to recompute q*b+r with a
// crosswise (Urdhva-Tiryagbhyam) multiplier and flag chk_err on mismatch.
import vedic_div_pkg::*;

module vedic_seq_divider #(
    parameter int WIDTH = DIV_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             chk_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-2:0] qs;
    logic [CW-1:0]    cnt;

    logic             dbit;
    logic [WIDTH-1:0] acc_nxt;
    logic             qbit;
    logic [WIDTH-1:0] q_fin;
    logic             chk_nxt;

    // dividend bit selected by the down-counter (MSB first)
    assign dbit  = |(a_reg & (WIDTH'(1) << cnt));
    assign q_fin = {qs, qbit};

    vedic_div_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .dbit    (dbit),
        .divisor (b_reg),
        .acc_nxt (acc_nxt),
        .qbit    (qbit)
    );

`ifdef VEDIC_DIV_CHECK_EN
    // crosswise multiply: each output column sums the partial products a[i]&b[k-i]
    function automatic logic [2*WIDTH-1:0] vedic_mul(input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] p;
        int                 col;
        p = '0;
        for (int k = 0; k < 2*WIDTH-1; k++) begin
            col = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if (k >= i && (k - i) < WIDTH) begin
                    if (|(x & (WIDTH'(1) << i)) && |(y & (WIDTH'(1) << (k - i))))
                        col++;
                end
            end
            p = p + ((2*WIDTH)'(col) << k);
        end
        return p;
    endfunction

    // recombine the final quotient/remainder and compare with the dividend
    always_comb begin
        chk_nxt = (vedic_mul(q_fin, b_reg) + (2*WIDTH)'(acc_nxt)) != (2*WIDTH)'(a_reg);
    end
`else
    // checker absent: the flag stays low
    always_comb begin
        chk_nxt = 1'b0;
    end
`endif

    // control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            chk_err     <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            qs          <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        qs    <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        if (b == '0) begin
                            // nothing to iterate: publish the div-by-zero result now
                            state       <= DONE;
                            done        <= 1'b1;
                            q           <= '1;
                            r           <= a;
                            div_by_zero <= 1'b1;
                            chk_err     <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nxt[WIDTH-2:0];
                    qs  <= q_fin[WIDTH-2:0];
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        q           <= q_fin;
                        r           <= acc_nxt;
                        div_by_zero <= 1'b0;
                        chk_err     <= chk_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Self-checking bench for vedic_seq_divider (WIDTH=4): directed cases, handshake,
// mid-op reset, exhaustive sweep and random operands against plain / and %.
module tb_vedic_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero, chk_err;
    logic [W-1:0] q, r;

    int checks = 0;
    int errors = 0;

    vedic_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero),
        .chk_err     (chk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // wait (sampling on negedges) for done; n = cycles after accept, nb = busy cycles seen
    task automatic wait_done(output int n, output int nb);
        n  = 1;
        nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    // compare held results against the arithmetic reference
    task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int eq, er;
        if (y == 0) begin
            eq = (1 << W) - 1;
            er = x;
        end else begin
            eq = int'(x) / int'(y);
            er = int'(x) % int'(y);
        end
        chk({tag, "_q"},   32'(q), 32'(eq));
        chk({tag, "_r"},   32'(r), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(y == 0));
        chk({tag, "_chk"}, 32'(chk_err), 32'd0);
    endtask

    // full operation from an idle/done state, including latency and busy length
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        int n, nb;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk({tag, "_lat"},  32'(n),  (y == 0) ? 32'd1 : 32'(W + 1));
        chk({tag, "_busy"}, 32'(nb), (y == 0) ? 32'd0 : 32'(W));
        check_result(tag, x, y);
    endtask

    initial begin
        int n, nb, nd;
        logic [W-1:0] rx, ry;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q",    32'(q), 0);
        chk("rst_r",    32'(r), 0);
        chk("rst_dbz",  32'(div_by_zero), 0);
        chk("rst_chk",  32'(chk_err), 0);
        rst_n = 1'b1;

        // basic, divide-by-zero, boundaries
        run_op("basic", 4'd13, 4'd3);
        run_op("dbz",   4'd7,  4'd0);
        run_op("b15_1", 4'd15, 4'd1);
        run_op("b2_9",  4'd2,  4'd9);
        run_op("b0_5",  4'd0,  4'd5);

        // start while busy ignored, then back-to-back accept in the done cycle
        @(negedge clk);
        a = 4'd15; b = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd9; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        chk("hs_lat", 32'(n), 32'(W - 1));
        check_result("hs_first", 4'd15, 4'd4);
        a = 4'd9; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        wait_done(n, nb);
        chk("b2b_lat", 32'(n), 32'(W + 1));
        check_result("b2b", 4'd9, 4'd2);

        // reset on the 2nd RUN cycle aborts without done
        @(negedge clk);
        a = 4'd13; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_q",    32'(q), 0);
        chk("mid_r",    32'(r), 0);
        chk("mid_dbz",  32'(div_by_zero), 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("mid_nodone", 32'(nd), 0);
        run_op("after_rst", 4'd6, 4'd3);

        // exhaustive sweep, b != 0
        for (int x = 0; x < (1 << W); x++)
            for (int y = 1; y < (1 << W); y++)
                run_op("exh", W'(x), W'(y));

        // random operands, divide-by-zero included
        repeat (60) begin
            rx = W'($urandom_range(0, (1 << W) - 1));
            ry = W'($urandom_range(0, (1 << W) - 1));
            run_op("rnd", rx, ry);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
